// File: rtl/sobel_window_filter.sv
// Sobel gradient magnitude over a 3x3 window built from three-row columns.
// Optional SOBEL_THRESH_EN binarises the output against THRESHOLD.
module sobel_window_filter #(
  parameter int unsigned           DATA_WIDTH = 12,
  parameter int unsigned           IMG_WIDTH  = 640,
  parameter logic [DATA_WIDTH-1:0] THRESHOLD  = 12'd1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] row0_pixel,
  input  logic [DATA_WIDTH-1:0] row1_pixel,
  input  logic [DATA_WIDTH-1:0] row2_pixel,
  input  logic                  row1_pixel_edge,
  input  logic                  row1_pixel_valid,
  output logic [DATA_WIDTH-1:0] edge_pixel,
  output logic                  edge_pixel_valid,
  output logic                  edge_pixel_sol,
  output logic                  line_overrun
);

  localparam int unsigned CW = $clog2(IMG_WIDTH) + 1;
  localparam int unsigned GW = DATA_WIDTH + 4;
  localparam logic [CW-1:0] ColLimit = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] ColLast  = CW'(IMG_WIDTH - 1);

  // Index 0 is the newest (rightmost) column, index 2 the oldest (leftmost).
  logic [2:0][DATA_WIDTH-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [CW-1:0]              col_q, col_d, pix_col;
  logic [1:0]                 lc_q, lc_d;
  logic                       ovr_q, ovr_d;
  logic                       s0_valid_q, s0_valid_d, s0_sol_q, s0_sol_d;
  logic [DATA_WIDTH-1:0]      pix_q, pix_d;
  logic                       valid_q, valid_d, sol_q, sol_d;

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        abs_x, abs_y, mag;
  logic [DATA_WIDTH-1:0] mag_out;

  function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] px);
    return $signed(GW'(px));
  endfunction

  always_comb begin
    top_d      = top_q;
    mid_d      = mid_q;
    bot_d      = bot_q;
    col_d      = col_q;
    lc_d       = lc_q;
    ovr_d      = ovr_q;
    s0_valid_d = 1'b0;
    s0_sol_d   = 1'b0;
    pix_col    = row1_pixel_edge ? '0 : col_q;
    if (row1_pixel_valid) begin
      top_d = {top_q[1], top_q[0], row2_pixel};
      mid_d = {mid_q[1], mid_q[0], row1_pixel};
      bot_d = {bot_q[1], bot_q[0], row0_pixel};
      if (row1_pixel_edge) begin
        col_d = CW'(1);
        lc_d  = (lc_q == 2'd3) ? lc_q : lc_q + 2'd1;
      end else if (col_q == ColLimit) begin
        ovr_d = 1'b1;
      end else begin
        col_d = col_q + CW'(1);
      end
      s0_valid_d = (lc_d == 2'd3) && (pix_col >= CW'(2)) && (pix_col <= ColLast);
      s0_sol_d   = s0_valid_d && (pix_col == CW'(2));
    end
  end

  // Gradients are taken from the window as it stood after the qualifying accept;
  // later accepts only change it at the end of this cycle, so gaps do not matter.
  always_comb begin
    gx = (ext(top_q[0]) + ext(mid_q[0]) + ext(mid_q[0]) + ext(bot_q[0]))
       - (ext(top_q[2]) + ext(mid_q[2]) + ext(mid_q[2]) + ext(bot_q[2]));
    gy = (ext(bot_q[2]) + ext(bot_q[1]) + ext(bot_q[1]) + ext(bot_q[0]))
       - (ext(top_q[2]) + ext(top_q[1]) + ext(top_q[1]) + ext(top_q[0]));
    abs_x = gx[GW-1] ? GW'(-gx) : GW'(gx);
    abs_y = gy[GW-1] ? GW'(-gy) : GW'(gy);
    mag   = abs_x + abs_y;
  end

`ifdef SOBEL_THRESH_EN
  assign mag_out = (mag > GW'(THRESHOLD)) ? '1 : '0;
`else
  assign mag_out = (|mag[GW-1:DATA_WIDTH]) ? '1 : mag[DATA_WIDTH-1:0];
  logic unused_thresh;
  assign unused_thresh = ^THRESHOLD;
`endif

  always_comb begin
    valid_d = s0_valid_q;
    sol_d   = s0_sol_q;
    pix_d   = s0_valid_q ? mag_out : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q      <= '0;
      mid_q      <= '0;
      bot_q      <= '0;
      col_q      <= '0;
      lc_q       <= '0;
      ovr_q      <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_sol_q   <= 1'b0;
      pix_q      <= '0;
      valid_q    <= 1'b0;
      sol_q      <= 1'b0;
    end else begin
      top_q      <= top_d;
      mid_q      <= mid_d;
      bot_q      <= bot_d;
      col_q      <= col_d;
      lc_q       <= lc_d;
      ovr_q      <= ovr_d;
      s0_valid_q <= s0_valid_d;
      s0_sol_q   <= s0_sol_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      sol_q      <= sol_d;
    end
  end

  assign edge_pixel       = pix_q;
  assign edge_pixel_valid = valid_q;
  assign edge_pixel_sol   = sol_q;
  assign line_overrun     = ovr_q;

endmodule

// File: tb/tb_sobel_window_filter.sv
// Self-checking bench: per-cycle scoreboard fed by a line-indexed Sobel model.
module tb_sobel_window_filter;
  localparam int DW = 12;
  localparam int W  = 8;
  localparam int MAXC = 4096;
  localparam logic [DW-1:0] TH = 12'd30;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] row0_pixel = '0, row1_pixel = '0, row2_pixel = '0;
  logic          row1_pixel_edge = 1'b0, row1_pixel_valid = 1'b0;
  logic [DW-1:0] edge_pixel;
  logic          edge_pixel_valid, edge_pixel_sol, line_overrun;

  always #5 clk = ~clk;

  sobel_window_filter #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .THRESHOLD (TH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .row0_pixel      (row0_pixel),
    .row1_pixel      (row1_pixel),
    .row2_pixel      (row2_pixel),
    .row1_pixel_edge (row1_pixel_edge),
    .row1_pixel_valid(row1_pixel_valid),
    .edge_pixel      (edge_pixel),
    .edge_pixel_valid(edge_pixel_valid),
    .edge_pixel_sol  (edge_pixel_sol),
    .line_overrun    (line_overrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_v [MAXC];
  int exp_p [MAXC];
  bit exp_s [MAXC];
  int ovr_cycle = -1;
  int m_lines = 0;
  int m_next = 0;
  int lt [W], lm [W], lb [W];
  int res_q [$];
  int nres = 0;
  int at [W], am [W], ab [W];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int shape(input int mag);
`ifdef SOBEL_THRESH_EN
    return (mag > int'(TH)) ? 4095 : 0;
`else
    return (mag > 4095) ? 4095 : mag;
`endif
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Result for centre column k-1 of the current line, straight from the formula.
  function automatic int sobel_at(input int k);
    int gx, gy;
    gx = (lt[k] + 2 * lm[k] + lb[k]) - (lt[k-2] + 2 * lm[k-2] + lb[k-2]);
    gy = (lb[k-2] + 2 * lb[k-1] + lb[k]) - (lt[k-2] + 2 * lt[k-1] + lt[k]);
    return shape(iabs(gx) + iabs(gy));
  endfunction

  task automatic check_outputs();
    int c;
    c = (cyc < MAXC) ? cyc : MAXC - 1;
    chk("valid", 32'(edge_pixel_valid), 32'(exp_v[c]));
    chk("pixel", 32'(edge_pixel), 32'(exp_p[c]));
    chk("sol", 32'(edge_pixel_sol), 32'(exp_s[c]));
    chk("overrun", 32'(line_overrun), 32'((ovr_cycle >= 0) && (cyc >= ovr_cycle)));
    if (edge_pixel_valid === 1'b1) begin
      res_q.push_back(int'(edge_pixel));
      nres++;
    end
  endtask

  task automatic step(input bit v, input bit e, input int t, input int m, input int b);
    int k;
    row2_pixel       = DW'(t);
    row1_pixel       = DW'(m);
    row0_pixel       = DW'(b);
    row1_pixel_edge  = e;
    row1_pixel_valid = v;
    if (v) begin
      if (e) begin
        k = 0;
        if (m_lines < 3) m_lines++;
      end else begin
        k = m_next;
      end
      m_next = k + 1;
      if (k >= W) begin
        if (ovr_cycle < 0) ovr_cycle = cyc + 1;
      end else begin
        lt[k] = t;
        lm[k] = m;
        lb[k] = b;
        if (m_lines == 3 && k >= 2 && cyc + 2 < MAXC) begin
          exp_v[cyc+2] = 1'b1;
          exp_p[cyc+2] = sobel_at(k);
          exp_s[cyc+2] = (k == 2);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
         int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
  endtask

  // gap_mode: 0 none, 1 idle cycle before every pixel, 2 random idles
  task automatic send_line(input int gap_mode);
    for (int k = 0; k < W; k++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) idle_step();
      step(1'b1, k == 0, at[k], am[k], ab[k]);
    end
  endtask

  task automatic flush();
    idle_step();
    idle_step();
  endtask

  task automatic fill_cols(input int lo_t, input int lo_m, input int lo_b,
                           input int hi_t, input int hi_m, input int hi_b);
    for (int k = 0; k < W; k++) begin
      at[k] = (k < 4) ? lo_t : hi_t;
      am[k] = (k < 4) ? lo_m : hi_m;
      ab[k] = (k < 4) ? lo_b : hi_b;
    end
  endtask

  task automatic expect_results(input string tag, input int e0, input int e1, input int e2,
                                input int e3, input int e4, input int e5);
    int ev [6];
    ev = '{e0, e1, e2, e3, e4, e5};
    chk({tag, "_count"}, 32'(res_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk(tag, (i < res_q.size()) ? 32'(res_q[i]) : 32'hffff_ffff, 32'(shape(ev[i])));
    res_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(edge_pixel_valid), 32'd0);
    chk("rst_pixel", 32'(edge_pixel), 32'd0);
    chk("rst_sol", 32'(edge_pixel_sol), 32'd0);
    chk("rst_overrun", 32'(line_overrun), 32'd0);
    for (int i = 0; i < MAXC; i++) begin
      exp_v[i] = 1'b0;
      exp_p[i] = 0;
      exp_s[i] = 1'b0;
    end
    m_lines = 0;
    m_next = 0;
    ovr_cycle = -1;
    row1_pixel_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    res_q.delete();
  endtask

  initial begin
    int n0;
    #2;
    do_reset();

    // Flat field: 4 lines of 100, only the last two yield results.
    fill_cols(100, 100, 100, 100, 100, 100);
    n0 = nres;
    for (int l = 0; l < 4; l++) send_line(0);
    flush();
    chk("flat_count", 32'(nres - n0), 32'd12);
    res_q.delete();

    fill_cols(0, 0, 0, 10, 10, 10);
    send_line(0);
    flush();
    expect_results("vstep10", 0, 0, 40, 40, 0, 0);

    fill_cols(0, 0, 0, 4095, 4095, 4095);
    send_line(0);
    flush();
    expect_results("vstep4095", 0, 0, 16380, 16380, 0, 0);

    fill_cols(0, 4095, 4095, 0, 4095, 4095);
    send_line(0);
    flush();
    expect_results("hstep4095", 16380, 16380, 16380, 16380, 16380, 16380);

    fill_cols(0, 5, 5, 0, 5, 5);
    send_line(0);
    flush();
    expect_results("hstep5", 20, 20, 20, 20, 20, 20);

    fill_cols(0, 0, 0, 10, 10, 10);
    send_line(1);
    flush();
    expect_results("gapped", 0, 0, 40, 40, 0, 0);

    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < W; k++) begin
        at[k] = int'($urandom_range(0, 4095));
        am[k] = int'($urandom_range(0, 4095));
        ab[k] = (l == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4095));
      end
      send_line(2);
    end
    flush();
    res_q.delete();

    // Overrun: an edge pixel then nine more without edge.
    n0 = nres;
    step(1'b1, 1'b1, 7, 7, 7);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 7 * i, 50, 3 * i);
    flush();
    chk("overrun_results", 32'(nres - n0), 32'd6);
    chk("overrun_flag", 32'(line_overrun), 32'd1);

    // Reset with results in flight, then three fresh lines.
    step(1'b1, 1'b1, 1, 2, 3);
    step(1'b1, 1'b0, 400, 900, 1200);
    step(1'b1, 1'b0, 0, 4000, 4000);
    step(1'b1, 1'b0, 4000, 0, 30);
    do_reset();
    for (int k = 0; k < W; k++) begin
      at[k] = int'($urandom_range(0, 4095));
      am[k] = int'($urandom_range(0, 4095));
      ab[k] = int'($urandom_range(0, 4095));
    end
    n0 = nres;
    send_line(0);
    send_line(2);
    flush();
    chk("post_rst_two_lines", 32'(nres - n0), 32'd0);
    send_line(0);
    flush();
    chk("post_rst_third_line", 32'(nres - n0), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
